// File: rtl/maze_wall_renderer.sv
// Maze wall renderer: draws a COLS x ROWS cell grid with per-edge walls and a forced border.
// Wall maps are double-buffered and promoted only at the frame boundary, so a frame never tears.
module maze_wall_renderer #(
  parameter int          COLS     = 5,
  parameter int          ROWS     = 5,
  parameter int          CELL     = 80,
  parameter int          WALL     = 2,
  parameter int          ORIGIN_X = 120,
  parameter int          ORIGIN_Y = 0,
  parameter int          V_ACTIVE = 480,
  parameter logic [11:0] WALL_RGB = 12'hFFF,
  parameter logic [11:0] BG_RGB   = 12'h000
) (
  input  logic                 pixel_clk,
  input  logic                 reset,
  input  logic [10:0]          hcount,
  input  logic [10:0]          vcount,
  input  logic                 blank,
  input  logic                 hs_in,
  input  logic                 vs_in,
  input  logic [COLS*ROWS-1:0] map_h,
  input  logic [COLS*ROWS-1:0] map_v,
  input  logic                 map_load,
  output logic                 map_ack,
  output logic                 frame_swap,
  output logic [3:0]           vga_r,
  output logic [3:0]           vga_g,
  output logic [3:0]           vga_b,
  output logic                 hs_out,
  output logic                 vs_out
);

  localparam int NB = COLS * ROWS;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;

  localparam logic [7:0]    CELL_LAST = 8'(CELL - 1);
  localparam logic [7:0]    WALL_EDGE = 8'(CELL - WALL);
  localparam logic [7:0]    WALL_T    = 8'(WALL);
  localparam logic [3:0]    COL_LAST  = 4'(COLS - 1);
  localparam logic [3:0]    ROW_LAST  = 4'(ROWS - 1);
  localparam logic [IW-1:0] ROWS_W    = IW'(ROWS);
  localparam logic [10:0]   OX        = 11'(ORIGIN_X);
  localparam logic [10:0]   OY        = 11'(ORIGIN_Y);
  localparam logic [10:0]   VB        = 11'(V_ACTIVE);

  function automatic logic is_wall(input logic ix, input logic iy,
                                   input logic [7:0] xo, input logic [7:0] yo,
                                   input logic [3:0] c, input logic [3:0] r,
                                   input logic bh, input logic bv);
    logic w;
    w = ((yo >= WALL_EDGE) && (bh || (r == ROW_LAST))) ||
        ((xo >= WALL_EDGE) && (bv || (c == COL_LAST))) ||
        ((c == 4'd0) && (xo < WALL_T)) ||
        ((r == 4'd0) && (yo < WALL_T));
    return ix && iy && w;
  endfunction

  logic [NB-1:0] shadow_h, shadow_v, active_h, active_v;
  logic          pending;
  logic          boundary;

  assign boundary = (hcount == 11'd0) && (vcount == VB);

  // A load on the boundary cycle still swaps in the previous shadow; the new map waits a frame.
  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      shadow_h   <= '0;
      shadow_v   <= '0;
      active_h   <= '0;
      active_v   <= '0;
      pending    <= 1'b0;
      map_ack    <= 1'b0;
      frame_swap <= 1'b0;
    end else begin
      map_ack    <= map_load;
      frame_swap <= boundary && pending;
      if (boundary && pending) begin
        active_h <= shadow_h;
        active_v <= shadow_v;
      end
      if (map_load) begin
        shadow_h <= map_h;
        shadow_v <= map_v;
        pending  <= 1'b1;
      end else if (boundary && pending) begin
        pending  <= 1'b0;
      end
    end
  end

  // Stage 1: incremental cell/offset trackers plus registered blank and syncs.
  logic [7:0] xoff_p1, yoff_p1;
  logic [3:0] col_p1, row_p1;
  logic       in_x_p1, in_y_p1;
  logic       vld_p1, hs_p1, vs_p1;

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      xoff_p1 <= '0;
      col_p1  <= '0;
      in_x_p1 <= 1'b0;
      yoff_p1 <= '0;
      row_p1  <= '0;
      in_y_p1 <= 1'b0;
      vld_p1  <= 1'b0;
      hs_p1   <= 1'b0;
      vs_p1   <= 1'b0;
    end else begin
      vld_p1 <= ~blank;
      hs_p1  <= hs_in;
      vs_p1  <= vs_in;

      if (hcount == OX) begin
        xoff_p1 <= '0;
        col_p1  <= '0;
        in_x_p1 <= 1'b1;
      end else if (in_x_p1) begin
        if (xoff_p1 == CELL_LAST) begin
          xoff_p1 <= '0;
          if (col_p1 == COL_LAST) in_x_p1 <= 1'b0;
          else                    col_p1  <= col_p1 + 4'd1;
        end else begin
          xoff_p1 <= xoff_p1 + 8'd1;
        end
      end

      if (hcount == 11'd0) begin
        if (vcount == OY) begin
          yoff_p1 <= '0;
          row_p1  <= '0;
          in_y_p1 <= 1'b1;
        end else if (in_y_p1) begin
          if (yoff_p1 == CELL_LAST) begin
            yoff_p1 <= '0;
            if (row_p1 == ROW_LAST) in_y_p1 <= 1'b0;
            else                    row_p1  <= row_p1 + 4'd1;
          end else begin
            yoff_p1 <= yoff_p1 + 8'd1;
          end
        end
      end
    end
  end

  logic [IW-1:0] idx_p1;
  logic          wall_p1;

  assign idx_p1  = IW'(col_p1) * ROWS_W + IW'(row_p1);
  assign wall_p1 = is_wall(in_x_p1, in_y_p1, xoff_p1, yoff_p1, col_p1, row_p1,
                           active_h[idx_p1], active_v[idx_p1]);

  // Stage 2: colour decision and sync alignment.
  logic [11:0] rgb_p2;
  logic        hs_p2, vs_p2;

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      rgb_p2 <= '0;
      hs_p2  <= 1'b0;
      vs_p2  <= 1'b0;
    end else begin
      rgb_p2 <= !vld_p1 ? 12'h000 : (wall_p1 ? WALL_RGB : BG_RGB);
      hs_p2  <= hs_p1;
      vs_p2  <= vs_p1;
    end
  end

  assign {vga_r, vga_g, vga_b} = rgb_p2;
  assign hs_out = hs_p2;
  assign vs_out = vs_p2;

endmodule

// File: tb/tb_maze_wall_renderer.sv
// Randomized bench for maze_wall_renderer on a shrunken raster, checked against a
// coordinate-arithmetic reference model of the maze, map double-buffering and reset behaviour.
module tb_maze_wall_renderer;

  localparam int          COLS     = 4;
  localparam int          ROWS     = 3;
  localparam int          CELL     = 6;
  localparam int          WALL     = 2;
  localparam int          OX       = 5;
  localparam int          OY       = 2;
  localparam int          V_ACT    = 24;
  localparam int          H_ACT    = 36;
  localparam int          H_TOT    = 40;
  localparam int          V_TOT    = 28;
  localparam int          NB       = COLS * ROWS;
  localparam int          NFRAMES  = 36;
  localparam logic [11:0] WALL_C   = 12'hA5C;
  localparam logic [11:0] BG_C     = 12'h312;

  logic          pixel_clk;
  logic          reset;
  logic [10:0]   hcount, vcount;
  logic          blank, hs_in, vs_in;
  logic [NB-1:0] map_h, map_v;
  logic          map_load;
  logic          map_ack, frame_swap;
  logic [3:0]    vga_r, vga_g, vga_b;
  logic          hs_out, vs_out;

  maze_wall_renderer #(
    .COLS(COLS), .ROWS(ROWS), .CELL(CELL), .WALL(WALL),
    .ORIGIN_X(OX), .ORIGIN_Y(OY), .V_ACTIVE(V_ACT),
    .WALL_RGB(WALL_C), .BG_RGB(BG_C)
  ) dut (
    .pixel_clk(pixel_clk), .reset(reset),
    .hcount(hcount), .vcount(vcount), .blank(blank),
    .hs_in(hs_in), .vs_in(vs_in),
    .map_h(map_h), .map_v(map_v), .map_load(map_load),
    .map_ack(map_ack), .frame_swap(frame_swap),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .hs_out(hs_out), .vs_out(vs_out)
  );

  initial pixel_clk = 1'b0;
  always #5 pixel_clk = ~pixel_clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Reference state: latest loaded map, displayed map, and whether the raster has re-synced.
  logic [NB-1:0] m_shadow_h = '0, m_shadow_v = '0, m_active_h = '0, m_active_v = '0;
  bit            m_pending = 0;
  bit            m_synced  = 0;
  logic [13:0]   e_p1 = '0, e_p2 = '0;
  logic          e_ack = 0, e_swap = 0;
  int            swaps_seen = 0, swaps_exp = 0;

  function automatic logic [11:0] model_rgb(input int h, input int v, input bit bl,
                                            input bit synced,
                                            input logic [NB-1:0] mh, input logic [NB-1:0] mv);
    int x, y, c, r, xo, yo, i;
    bit w;
    if (bl) return 12'h000;
    x = h - OX;
    y = v - OY;
    if (!synced || x < 0 || x >= COLS * CELL || y < 0 || y >= ROWS * CELL) return BG_C;
    c  = x / CELL;  xo = x % CELL;
    r  = y / CELL;  yo = y % CELL;
    i  = ROWS * c + r;
    w  = ((yo >= CELL - WALL) && (mh[4'(i)] || r == ROWS - 1)) ||
         ((xo >= CELL - WALL) && (mv[4'(i)] || c == COLS - 1)) ||
         (c == 0 && xo < WALL) ||
         (r == 0 && yo < WALL);
    return w ? WALL_C : BG_C;
  endfunction

  task automatic step(input int h, input int v);
    logic [13:0] pix;
    bit bnd;
    @(posedge pixel_clk);
    if (reset) m_synced = 0;
    else if (h == 0 && v == OY) m_synced = 1;
    pix  = {model_rgb(h, v, blank, m_synced, m_active_h, m_active_v), hs_in, vs_in};
    e_p2 = reset ? 14'd0 : e_p1;
    e_p1 = reset ? 14'd0 : pix;
    if (reset) begin
      m_shadow_h = '0; m_shadow_v = '0; m_active_h = '0; m_active_v = '0;
      m_pending = 0; e_ack = 0; e_swap = 0;
    end else begin
      bnd    = (h == 0 && v == V_ACT);
      e_ack  = map_load;
      e_swap = bnd && m_pending;
      if (e_swap) begin
        m_active_h = m_shadow_h;
        m_active_v = m_shadow_v;
      end
      if (map_load) begin
        m_shadow_h = map_h;
        m_shadow_v = map_v;
        m_pending  = 1;
      end else if (e_swap) begin
        m_pending = 0;
      end
    end
    if (e_swap) swaps_exp++;
    #1;
    if (frame_swap === 1'b1) swaps_seen++;
    chk("pixel_rgb_hs_vs", 32'({vga_r, vga_g, vga_b, hs_out, vs_out}), 32'(e_p2));
    chk("map_ack", 32'(map_ack), 32'(e_ack));
    chk("frame_swap", 32'(frame_swap), 32'(e_swap));
  endtask

  initial begin
    int frame_len, p1, p2, rpos, rlen, pos;
    bit bload;
    frame_len = H_TOT * V_TOT;
    reset = 1'b1; hcount = '0; vcount = '0; blank = 1'b1;
    hs_in = 1'b0; vs_in = 1'b0; map_h = '0; map_v = '0; map_load = 1'b0;
    #1;
    for (int fr = 0; fr < NFRAMES; fr++) begin
      p1    = $urandom_range(0, 2 * frame_len);
      p2    = (fr % 3 == 1) ? $urandom_range(0, frame_len - 1) : 2 * frame_len + 1;
      bload = (fr % 4 == 3);
      if (fr == 0) begin
        rpos = 0; rlen = 3;
      end else if (fr % 7 == 5) begin
        rpos = $urandom_range(0, frame_len - 1); rlen = $urandom_range(1, 3);
      end else begin
        rpos = 3 * frame_len; rlen = 0;
      end
      for (int v = 0; v < V_TOT; v++) begin
        for (int h = 0; h < H_TOT; h++) begin
          pos      = v * H_TOT + h;
          hcount   = 11'(h);
          vcount   = 11'(v);
          blank    = (h >= H_ACT) || (v >= V_ACT) || ($urandom_range(0, 63) == 0);
          hs_in    = 1'($urandom);
          vs_in    = 1'($urandom);
          map_h    = NB'($urandom);
          map_v    = NB'($urandom);
          map_load = (pos == p1) || (pos == p2) || (bload && pos == V_ACT * H_TOT);
          reset    = (pos >= rpos) && (pos < rpos + rlen);
          step(h, v);
        end
      end
    end
    chk("frame_swap_count", 32'(swaps_seen), 32'(swaps_exp));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
